// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-order car controller with timed floor travel and door dwell.
// Define ELEV_OBSTRUCT_EN to add the obstruct input and the sticky obstruct_alarm output.
module elevator_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3,
    localparam int FW         = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FW-1:0]         req_floor,
    input  logic                  door_hold,
`ifdef ELEV_OBSTRUCT_EN
    input  logic                  obstruct,
    output logic                  obstruct_alarm,
`endif
    output logic [FW-1:0]         floor,
    output logic                  door,
    output logic                  moving,
    output logic [1:0]            dir,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  req_err
);

    localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [MCW-1:0] MOVE_LOAD = MCW'(MOVE_CYCLES - 1);
    localparam logic [DCW-1:0] DOOR_LOAD = DCW'(DOOR_CYCLES - 1);
    localparam logic [FW:0]    NF_W      = (FW + 1)'(NUM_FLOORS);
    localparam logic [FW-1:0]  TOP_FLOOR = FW'(NUM_FLOORS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_OPEN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  req_err_q, req_err_d;
    logic                  last_dir_q, last_dir_d;
    logic [MCW-1:0]        mcnt_q, mcnt_d;
    logic [DCW-1:0]        dtmr_q, dtmr_d;

    logic                  req_ok;
    logic                  same_floor;
    logic [NUM_FLOORS-1:0] req_bit;
    logic [NUM_FLOORS-1:0] cur_bit;
    logic [NUM_FLOORS-1:0] pend_in;
    logic [NUM_FLOORS-1:0] arrive_bit;
    logic [NUM_FLOORS-1:0] ahead_n;
    logic [FW-1:0]         floor_n;
    logic                  at_end;
    logic                  hold_in;
    logic                  move_ok;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FW-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FW'(i) == f);
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_of(input logic [FW-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FW'(i) > f);
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_of(input logic [FW-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FW'(i) < f);
        return m;
    endfunction

`ifdef ELEV_OBSTRUCT_EN
    localparam int OCW = $clog2(4 * DOOR_CYCLES);
    localparam logic [OCW-1:0] OBS_LAST = OCW'(4 * DOOR_CYCLES - 1);

    logic [OCW-1:0] ocnt_q, ocnt_d;
    logic           alarm_q, alarm_d;

    // Consecutive-cycle counter saturates; alarm is sticky until reset.
    always_comb begin
        ocnt_d  = '0;
        alarm_d = alarm_q;
        if (obstruct) begin
            ocnt_d = (ocnt_q == OBS_LAST) ? ocnt_q : ocnt_q + 1'b1;
            if (ocnt_q == OBS_LAST) alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocnt_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            ocnt_q  <= ocnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign hold_in        = door_hold | obstruct;
    assign move_ok        = ~alarm_q;
    assign obstruct_alarm = alarm_q;
`else
    assign hold_in = door_hold;
    assign move_ok = 1'b1;
`endif

    always_comb begin
        req_err_d  = req_valid && ({1'b0, req_floor} >= NF_W);
        req_ok     = req_valid && !req_err_d;
        req_bit    = req_ok ? onehot(req_floor) : '0;
        same_floor = req_ok && (req_floor == floor_q);
        cur_bit    = onehot(floor_q);
        pend_in    = pending_q | req_bit;
        at_end     = last_dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
        floor_n    = last_dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
        arrive_bit = onehot(floor_n);
        ahead_n    = last_dir_q ? above_of(floor_n) : below_of(floor_n);

        state_d    = state_q;
        floor_d    = floor_q;
        pending_d  = pending_q;
        last_dir_d = last_dir_q;
        mcnt_d     = mcnt_q;
        dtmr_d     = dtmr_q;

        case (state_q)
            ST_IDLE: begin
                pending_d = pend_in & ~cur_bit;
                if (same_floor || (|(pending_q & cur_bit))) begin
                    state_d = ST_OPEN;
                    dtmr_d  = DOOR_LOAD;
                end else if ((|pending_q) && move_ok) begin
                    state_d = ST_MOVE;
                    mcnt_d  = MOVE_LOAD;
                    // Keep the previous direction if anything lies that way, else reverse.
                    if (last_dir_q) last_dir_d = |(pending_q & above_of(floor_q));
                    else            last_dir_d = ~(|(pending_q & below_of(floor_q)));
                end
            end
            ST_MOVE: begin
                pending_d = pend_in;
                if (mcnt_q != '0) begin
                    mcnt_d = mcnt_q - 1'b1;
                end else if (at_end) begin
                    state_d = ST_IDLE;
                end else begin
                    floor_d = floor_n;
                    // A request for the arriving floor on this edge is absorbed by the arrival.
                    if (|(pend_in & arrive_bit)) begin
                        state_d   = ST_OPEN;
                        pending_d = pend_in & ~arrive_bit;
                        dtmr_d    = DOOR_LOAD;
                    end else if (|(pend_in & ahead_n)) begin
                        mcnt_d = MOVE_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                pending_d = pend_in & ~cur_bit;
                if (hold_in || same_floor) begin
                    dtmr_d = DOOR_LOAD;
                end else if (dtmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    dtmr_d = dtmr_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            floor_q    <= '0;
            pending_q  <= '0;
            req_err_q  <= 1'b0;
            last_dir_q <= 1'b1;
            mcnt_q     <= '0;
            dtmr_q     <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            pending_q  <= pending_d;
            req_err_q  <= req_err_d;
            last_dir_q <= last_dir_d;
            mcnt_q     <= mcnt_d;
            dtmr_q     <= dtmr_d;
        end
    end

    assign floor   = floor_q;
    assign door    = (state_q == ST_OPEN);
    assign moving  = (state_q == ST_MOVE);
    assign dir     = (state_q == ST_MOVE) ? (last_dir_q ? 2'b01 : 2'b10) : 2'b00;
    assign pending = pending_q;
    assign req_err = req_err_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Table-driven bench for elevator_ctrl (8 floors, 4-cycle travel, 3-cycle dwell)
// plus a 6-floor instance for out-of-range requests.
module tb_elevator_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = 3'd0;
    logic       door_hold = 1'b0;
    logic [2:0] floor;
    logic       door, moving, req_err;
    logic [1:0] dir;
    logic [7:0] pending;

    logic       r6_valid = 1'b0;
    logic [2:0] r6_floor = 3'd0;
    logic [2:0] floor6;
    logic       door6, moving6, req_err6;
    logic [1:0] dir6;
    logic [5:0] pending6;

`ifdef ELEV_OBSTRUCT_EN
    logic obstruct  = 1'b0;
    logic obstruct6 = 1'b0;
    logic alarm, alarm6;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elevator_ctrl #(.NUM_FLOORS(8), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
        .door_hold(door_hold),
`ifdef ELEV_OBSTRUCT_EN
        .obstruct(obstruct), .obstruct_alarm(alarm),
`endif
        .floor(floor), .door(door), .moving(moving), .dir(dir),
        .pending(pending), .req_err(req_err)
    );

    elevator_ctrl #(.NUM_FLOORS(6), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(r6_valid), .req_floor(r6_floor),
        .door_hold(1'b0),
`ifdef ELEV_OBSTRUCT_EN
        .obstruct(obstruct6), .obstruct_alarm(alarm6),
`endif
        .floor(floor6), .door(door6), .moving(moving6), .dir(dir6),
        .pending(pending6), .req_err(req_err6)
    );

    typedef struct {
        logic       v;
        logic [2:0] f;
        logic       h;
        int         n;
        logic [2:0] fl;
        logic       d;
        logic       m;
        logic [1:0] dr;
        logic [7:0] p;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input int v, input int f, input int h, input int n,
                                input int fl, input int d, input int m,
                                input logic [1:0] dr, input logic [7:0] p);
        vec_t r;
        r.v  = v[0];
        r.f  = f[2:0];
        r.h  = h[0];
        r.n  = n;
        r.fl = fl[2:0];
        r.d  = d[0];
        r.m  = m[0];
        r.dr = dr;
        r.p  = p;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, floor, door, moving, dir, pending};
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t r);
        return {17'd0, r.fl, r.d, r.m, r.dr, r.p};
    endfunction

    initial begin
        // Request 3 from reset, then SCAN with {1,6} pending from floor 3, then door hold.
        tbl[0]  = mk(1, 3, 0, 1,  0, 0, 0, 2'b00, 8'h08);
        tbl[1]  = mk(0, 0, 0, 4,  0, 0, 1, 2'b01, 8'h08);
        tbl[2]  = mk(0, 0, 0, 4,  1, 0, 1, 2'b01, 8'h08);
        tbl[3]  = mk(0, 0, 0, 4,  2, 0, 1, 2'b01, 8'h08);
        tbl[4]  = mk(0, 0, 0, 3,  3, 1, 0, 2'b00, 8'h00);
        tbl[5]  = mk(0, 0, 0, 1,  3, 0, 0, 2'b00, 8'h00);
        tbl[6]  = mk(1, 6, 0, 1,  3, 0, 0, 2'b00, 8'h40);
        tbl[7]  = mk(1, 1, 0, 1,  3, 0, 1, 2'b01, 8'h42);
        tbl[8]  = mk(0, 0, 0, 3,  3, 0, 1, 2'b01, 8'h42);
        tbl[9]  = mk(0, 0, 0, 4,  4, 0, 1, 2'b01, 8'h42);
        tbl[10] = mk(0, 0, 0, 4,  5, 0, 1, 2'b01, 8'h42);
        tbl[11] = mk(0, 0, 0, 3,  6, 1, 0, 2'b00, 8'h02);
        tbl[12] = mk(0, 0, 0, 1,  6, 0, 0, 2'b00, 8'h02);
        tbl[13] = mk(0, 0, 0, 4,  6, 0, 1, 2'b10, 8'h02);
        tbl[14] = mk(0, 0, 0, 4,  5, 0, 1, 2'b10, 8'h02);
        tbl[15] = mk(0, 0, 0, 4,  4, 0, 1, 2'b10, 8'h02);
        tbl[16] = mk(0, 0, 0, 4,  3, 0, 1, 2'b10, 8'h02);
        tbl[17] = mk(0, 0, 0, 4,  2, 0, 1, 2'b10, 8'h02);
        tbl[18] = mk(0, 0, 0, 3,  1, 1, 0, 2'b00, 8'h00);
        tbl[19] = mk(0, 0, 0, 1,  1, 0, 0, 2'b00, 8'h00);
        tbl[20] = mk(1, 1, 0, 1,  1, 1, 0, 2'b00, 8'h00);
        tbl[21] = mk(0, 0, 1, 10, 1, 1, 0, 2'b00, 8'h00);
        tbl[22] = mk(0, 0, 0, 2,  1, 1, 0, 2'b00, 8'h00);
        tbl[23] = mk(0, 0, 0, 1,  1, 0, 0, 2'b00, 8'h00);

        tick();
        tick();
        check("reset_outs", outs(), 32'd0);
        check("reset_req_err", {31'd0, req_err}, 32'd0);
        check("reset6_outs", {18'd0, floor6, door6, moving6, dir6, pending6}, 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                req_valid = tbl[r].v;
                req_floor = tbl[r].f;
                door_hold = tbl[r].h;
                tick();
                check($sformatf("row%0d_cyc%0d", r, c), outs(), pack_exp(tbl[r]));
            end
        end
        req_valid = 1'b0;
        req_floor = 3'd0;
        door_hold = 1'b0;
        check("req_err_quiet", {31'd0, req_err}, 32'd0);

        // Asynchronous reset while travelling must clear state without waiting for an edge.
        req_valid = 1'b1;
        req_floor = 3'd5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("premove_state", outs(), {17'd0, 3'd1, 1'b0, 1'b1, 2'b01, 8'h20});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 32'd0);
        tick();
        rst_n = 1'b1;

        // Out-of-range request on the 6-floor build is flagged for one cycle and dropped.
        r6_valid = 1'b1;
        r6_floor = 3'd5;
        tick();
        check("r6_valid_pending", {26'd0, pending6}, 32'h20);
        check("r6_valid_err", {31'd0, req_err6}, 32'd0);
        r6_floor = 3'd6;
        tick();
        check("r6_oor_err", {31'd0, req_err6}, 32'd1);
        check("r6_oor_pending", {26'd0, pending6}, 32'h20);
        r6_valid = 1'b0;
        r6_floor = 3'd0;
        tick();
        check("r6_err_pulse", {31'd0, req_err6}, 32'd0);
        check("r6_pending_kept", {26'd0, pending6}, 32'h20);

`ifdef ELEV_OBSTRUCT_EN
        req_valid = 1'b1;
        req_floor = 3'd0;
        tick();
        req_valid = 1'b0;
        check("obs_open", {31'd0, door}, 32'd1);
        obstruct = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 11) check("obs_alarm_pre", {31'd0, alarm}, 32'd0);
        end
        check("obs_alarm_set", {31'd0, alarm}, 32'd1);
        check("obs_door_held", {31'd0, door}, 32'd1);
        obstruct = 1'b0;
        tick();
        tick();
        tick();
        check("obs_door_closed", {31'd0, door}, 32'd0);
        req_valid = 1'b1;
        req_floor = 3'd2;
        tick();
        req_valid = 1'b0;
        check("obs_req_latched", {24'd0, pending}, 32'h04);
        tick();
        tick();
        tick();
        check("obs_no_move", {31'd0, moving}, 32'd0);
        check("obs_alarm_sticky", {31'd0, alarm}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
